// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares a single-port sprite ROM (5-bit pixels, registered read with one
//   cycle of latency, synchronous write) between NUM_REQ burst fetchers and a
//   single loader write port. Bursts are granted round-robin and issue one
//   read per cycle. Each returned pixel is tagged with its owner id and a
//   last-beat flag. A pending loader write wins whenever the arbiter is idle.
//
// Ports
//   Clk, Reset         clock; synchronous active-low reset
//   req_valid/base/len per-requester burst request (len encoded as beats-1)
//   req_ready          one-hot grant pulse
//   rsp_valid/data/id/last  returned pixel stream
//   wr_req/addr/data   loader write request; wr_ack pulses when it is issued
//   rom_*              connection to the ROM macro
//   busy               FSM active or beats still in flight
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 21,
    parameter int DEPTH   = 101240,
    parameter int LEN_W   = 6,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_base,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [4:0]                rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_last,
    input  logic                      wr_req,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [4:0]                wr_data,
    output logic                      wr_ack,
    output logic                      rom_we,
    output logic [ADDR_W-1:0]         rom_write_address,
    output logic [4:0]                rom_data_in,
    output logic [ADDR_W-1:0]         rom_read_address,
    input  logic [4:0]                rom_data_out,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, WRITE, BURST} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t              state, state_d;
    logic [ID_W-1:0]     rr, rr_d;
    logic [ADDR_W-1:0]   cur_base, cur_base_d;
    logic [LEN_W-1:0]    cur_len, cur_len_d;
    logic [ID_W-1:0]     cur_id, cur_id_d;
    logic [LEN_W-1:0]    beat, beat_d;

    // Response tag pipeline: p1 travels with the registered read address,
    // p2 with the ROM's registered output.
    logic                vld_p1, vld_p1_d, vld_p2, vld_p2_d;
    logic [ID_W-1:0]     id_p1, id_p1_d, id_p2, id_p2_d;
    logic                last_p1, last_p1_d, last_p2, last_p2_d;
    logic                oob_p1, oob_p1_d, oob_p2, oob_p2_d;

    logic [NUM_REQ-1:0]  req_ready_d;
    logic                rsp_valid_d, rsp_last_d, wr_ack_d, rom_we_d, busy_d;
    logic [4:0]          rsp_data_d, rom_data_in_d;
    logic [ID_W-1:0]     rsp_id_d;
    logic [ADDR_W-1:0]   rom_write_address_d, rom_read_address_d;

    logic                grant_found;
    logic [ID_W-1:0]     grant_id;
    logic [ADDR_W-1:0]   beat_addr;

    assign beat_addr = cur_base + ADDR_W'(beat);

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d             = state;
        rr_d                = rr;
        cur_base_d          = cur_base;
        cur_len_d           = cur_len;
        cur_id_d            = cur_id;
        beat_d              = beat;
        req_ready_d         = '0;
        wr_ack_d            = 1'b0;
        rom_we_d            = 1'b0;
        rom_write_address_d = rom_write_address;
        rom_data_in_d       = rom_data_in;
        rom_read_address_d  = rom_read_address;
        vld_p1_d            = 1'b0;
        id_p1_d             = id_p1;
        last_p1_d           = last_p1;
        oob_p1_d            = oob_p1;

        // Tags advance unconditionally; oob beats (and idle cycles) return 0.
        vld_p2_d    = vld_p1;
        id_p2_d     = id_p1;
        last_p2_d   = last_p1;
        oob_p2_d    = oob_p1;
        rsp_valid_d = vld_p2;
        rsp_id_d    = id_p2;
        rsp_last_d  = last_p2;
        rsp_data_d  = (vld_p2 && !oob_p2) ? rom_data_out : 5'd0;

        case (state)
            IDLE: begin
                if (wr_req) begin
                    // Out-of-range writes are acknowledged but never reach the ROM.
                    rom_we_d            = (wr_addr < DEPTH_A);
                    rom_write_address_d = wr_addr;
                    rom_data_in_d       = wr_data;
                    wr_ack_d            = 1'b1;
                    state_d             = WRITE;
                end else if (grant_found) begin
                    req_ready_d[grant_id] = 1'b1;
                    cur_base_d = req_base[int'(grant_id)*ADDR_W +: ADDR_W];
                    cur_len_d  = req_len[int'(grant_id)*LEN_W +: LEN_W];
                    cur_id_d   = grant_id;
                    beat_d     = '0;
                    state_d    = BURST;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            BURST: begin
                rom_read_address_d = beat_addr;
                vld_p1_d           = 1'b1;
                id_p1_d            = cur_id;
                last_p1_d          = (beat == cur_len);
                oob_p1_d           = (beat_addr >= DEPTH_A);
                if (beat == cur_len) begin
                    rr_d    = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
                    state_d = IDLE;
                end else begin
                    beat_d = beat + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || vld_p1_d || vld_p2_d || rsp_valid_d;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state             <= IDLE;
            rr                <= '0;
            vld_p1            <= 1'b0;
            id_p1             <= '0;
            last_p1           <= 1'b0;
            oob_p1            <= 1'b0;
            vld_p2            <= 1'b0;
            id_p2             <= '0;
            last_p2           <= 1'b0;
            oob_p2            <= 1'b0;
            req_ready         <= '0;
            rsp_valid         <= 1'b0;
            rsp_data          <= '0;
            rsp_id            <= '0;
            rsp_last          <= 1'b0;
            wr_ack            <= 1'b0;
            rom_we            <= 1'b0;
            rom_write_address <= '0;
            rom_data_in       <= '0;
            rom_read_address  <= '0;
            busy              <= 1'b0;
        end else begin
            state             <= state_d;
            rr                <= rr_d;
            vld_p1            <= vld_p1_d;
            id_p1             <= id_p1_d;
            last_p1           <= last_p1_d;
            oob_p1            <= oob_p1_d;
            vld_p2            <= vld_p2_d;
            id_p2             <= id_p2_d;
            last_p2           <= last_p2_d;
            oob_p2            <= oob_p2_d;
            req_ready         <= req_ready_d;
            rsp_valid         <= rsp_valid_d;
            rsp_data          <= rsp_data_d;
            rsp_id            <= rsp_id_d;
            rsp_last          <= rsp_last_d;
            wr_ack            <= wr_ack_d;
            rom_we            <= rom_we_d;
            rom_write_address <= rom_write_address_d;
            rom_data_in       <= rom_data_in_d;
            rom_read_address  <= rom_read_address_d;
            busy              <= busy_d;
        end
    end

    // Burst context is only meaningful while in BURST, so it needs no reset.
    always_ff @(posedge Clk) begin
        cur_base <= cur_base_d;
        cur_len  <= cur_len_d;
        cur_id   <= cur_id_d;
        beat     <= beat_d;
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
//   Bench for sprite_rom_arbiter: behavioural ROM, table of burst vectors,
//   hand-written sequences for round-robin, write priority and mid-burst reset.
//   Expected pixels are queued when a request is driven and popped by the
//   response monitor.
module tb_sprite_rom_arbiter;

    localparam int NR = 4;
    localparam int AW = 21;
    localparam int DP = 101240;
    localparam int LW = 6;
    localparam int IW = 2;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_base;
    logic [NR*LW-1:0]  req_len;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [4:0]        rsp_data;
    logic [IW-1:0]     rsp_id;
    logic              rsp_last;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [4:0]        wr_data;
    logic              wr_ack;
    logic              rom_we;
    logic [AW-1:0]     rom_write_address;
    logic [4:0]        rom_data_in;
    logic [AW-1:0]     rom_read_address;
    logic [4:0]        rom_data_out;
    logic              busy;

    sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DEPTH(DP), .LEN_W(LW)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_base(req_base), .req_len(req_len),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_last(rsp_last),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rom_we(rom_we), .rom_write_address(rom_write_address), .rom_data_in(rom_data_in),
        .rom_read_address(rom_read_address), .rom_data_out(rom_data_out),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM model: initial content from pix(), overridden by issued writes.
    logic [4:0] wmem [int];

    function automatic logic [4:0] pix(input int a);
        if (a >= 100 && a <= 103) return 5'(a - 99);
        return 5'((a * 7 + 3) % 32);
    endfunction

    function automatic logic [4:0] model_rd(input int a);
        if (wmem.exists(a)) return wmem[a];
        return pix(a);
    endfunction

    // Out-of-range reads return a non-zero pattern so the arbiter must zero them.
    always @(posedge Clk) begin
        int ra;
        ra = int'(rom_read_address);
        rom_data_out <= (ra < DP) ? model_rd(ra) : 5'h15;
        if (rom_we) wmem[int'(rom_write_address)] = rom_data_in;
    end

    // Scoreboard
    typedef struct {
        int id;
        int data;
        int last;
        int beat;
    } exp_t;
    exp_t sbq[$];

    int first_rsp_cyc = -1;
    int last_rsp_cyc  = -1;

    always @(negedge Clk) begin
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected_valid", int'(rsp_valid), 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_data", int'(rsp_data), e.data);
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_last", int'(rsp_last), e.last);
                if (e.beat == 0) first_rsp_cyc = cyc;
                else chk("rsp_contiguous", cyc, last_rsp_cyc + 1);
                last_rsp_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_burst(input int id, input int base, input int len);
        for (int k = 0; k <= len; k++) begin
            exp_t e;
            int a;
            a      = base + k;
            e.id   = id;
            e.data = (a < DP) ? int'(model_rd(a)) : 0;
            e.last = (k == len) ? 1 : 0;
            e.beat = k;
            sbq.push_back(e);
        end
    endtask

    task automatic set_req(input int id, input int base, input int len);
        req_base[id*AW +: AW] = AW'(base);
        req_len[id*LW +: LW]  = LW'(len);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 20; n++) begin
            tick();
            if (req_ready != '0) return;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sbq.size() != 0; n++) tick();
        chk("drain_empty", sbq.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        tick();
        sbq.delete();
        Reset = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, int'(rsp_data), 0);
        chk({tag, "_rsp_last"}, int'(rsp_last), 0);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
        chk({tag, "_wr_ack"}, int'(wr_ack), 0);
        chk({tag, "_rom_we"}, int'(rom_we), 0);
        chk({tag, "_rd_addr"}, int'(rom_read_address), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    typedef struct {
        int id;
        int base;
        int len;
        int exp_ready;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int prev;
        int order[5];

        vecs[0] = '{2, 100, 3, 4};
        vecs[1] = '{1, 200, 0, 2};
        vecs[2] = '{3, 101238, 3, 8};
        vecs[3] = '{0, 4000, 7, 1};
        vecs[4] = '{2, 50, 1, 4};

        Reset = 1'b0; req_valid = '0; req_base = '0; req_len = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        tick();
        tick();
        chk_outputs_zero("reset");
        Reset = 1'b1;
        tick();

        // Table-driven single bursts
        foreach (vecs[i]) begin
            set_req(vecs[i].id, vecs[i].base, vecs[i].len);
            req_valid[vecs[i].id] = 1'b1;
            push_burst(vecs[i].id, vecs[i].base, vecs[i].len);
            wait_ready();
            chk("grant", int'(req_ready), vecs[i].exp_ready);
            req_valid = '0;
            prev = 0;
            for (int k = 0; k <= vecs[i].len; k++) begin
                tick();
                if (k == 0) prev = cyc;
                chk("rd_addr", int'(rom_read_address), vecs[i].base + k);
            end
            drain();
            chk("rsp_latency", first_rsp_cyc, prev + 2);
            chk("idle_busy", int'(busy), 0);
        end

        // Round-robin with all requesters held
        do_reset();
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NR; i++) set_req(i, 300 + 10 * i, 0);
        foreach (order[g]) push_burst(order[g], 300 + 10 * order[g], 0);
        req_valid = '1;
        prev = 0;
        foreach (order[g]) begin
            wait_ready();
            chk("rr_grant", int'(req_ready), 1 << order[g]);
            if (g > 0) chk("rr_gap", cyc - prev, 2);
            prev = cyc;
        end
        req_valid = '0;
        drain();

        // Write beats a simultaneous read, then readback
        do_reset();
        set_req(0, 5, 0);
        req_valid[0] = 1'b1;
        wr_req = 1'b1; wr_addr = AW'(5); wr_data = 5'h1F;
        sbq.push_back('{0, 31, 1, 0});
        tick();
        chk("wr_ack", int'(wr_ack), 1);
        chk("wr_we", int'(rom_we), 1);
        chk("wr_addr", int'(rom_write_address), 5);
        chk("wr_data", int'(rom_data_in), 31);
        chk("wr_no_grant", int'(req_ready), 0);
        wr_req = 1'b0;
        tick();
        chk("wr_ack_drop", int'(wr_ack), 0);
        chk("wr_we_drop", int'(rom_we), 0);
        chk("wr_no_grant2", int'(req_ready), 0);
        tick();
        chk("post_wr_grant", int'(req_ready), 1);
        req_valid = '0;
        tick();
        chk("post_wr_addr", int'(rom_read_address), 5);
        drain();

        // Out-of-range write is acked but never asserts rom_we
        wr_req = 1'b1; wr_addr = AW'(DP + 3); wr_data = 5'h07;
        tick();
        chk("oob_wr_ack", int'(wr_ack), 1);
        chk("oob_wr_we", int'(rom_we), 0);
        wr_req = 1'b0;
        tick();
        tick();

        // Reset during beat 10 of a 64-beat burst
        set_req(3, 1000, 63);
        req_valid[3] = 1'b1;
        push_burst(3, 1000, 63);
        wait_ready();
        chk("long_grant", int'(req_ready), 8);
        req_valid = '0;
        for (int k = 0; k <= 10; k++) tick();
        chk("beat10_addr", int'(rom_read_address), 1010);
        Reset = 1'b0;
        tick();
        sbq.delete();
        chk_outputs_zero("midrst");
        tick();
        Reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("post_rst_quiet", int'(rsp_valid), 0);
        end
        for (int i = 0; i < NR; i++) set_req(i, 300 + 10 * i, 0);
        push_burst(0, 300, 0);
        req_valid = '1;
        wait_ready();
        chk("post_rst_grant", int'(req_ready), 1);
        req_valid = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
